operand_stage: RTL and testbench

- Pipeline stage directly upstream of the 8-bit ALU: owns the 8x8 register file and the ID/EX pipeline register.
- Reads source operands, selects register or immediate for the second operand, and registers read1/read2/control for the ALU.
- Tracks pending register writes in a busy scoreboard and stalls on RAW/WAW hazards.
- Accepts write-back from the downstream stage and bypasses same-cycle write-back data into operand reads.

---
 rtl/operand_stage_pkg.sv | 19 +
 rtl/operand_stage_if.sv | 48 ++++
 rtl/operand_stage_regfile_2r1w.sv | 42 ++++
 rtl/operand_stage.sv | 104 ++++++++++
 tb/tb_operand_stage.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_stage_pkg.sv
// Shared constants for the operand stage and the ALU downstream of it.
package operand_stage_pkg;

  localparam int W    = 8;  // datapath width, matches the ALU operand width
  localparam int NREG = 8;  // architectural registers, r0 reads as zero
  localparam int AW   = 3;  // register address width

  // ALU operation codes; the ALU decodes the same values.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_SLT = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_NOT = 3'b110
  } alu_op_e;

endpackage

// File: rtl/operand_stage_if.sv
// Bus bundle of the operand stage: decode-side issue, write-back, EX-side output.
//
// Handshake rules:
//   issue : an instruction transfers on a rising edge where in_valid & in_ready
//           and flush is low; while in_valid is high and in_ready is low the
//           master holds the instruction fields stable.
//   output: EX consumes on a rising edge where ex_valid & ex_ready; while
//           ex_valid is high and ex_ready is low every output holds its value.
//           flush squashes the EX contents whatever ex_ready is.
interface operand_stage_if;
  import operand_stage_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [2:0]    alu_ctrl;
  logic          use_imm;
  logic [W-1:0]  imm;
  logic          reg_write;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          ex_ready;
  logic          flush;
  logic          ex_valid;
  logic [W-1:0]  read1;
  logic [W-1:0]  read2;
  logic [2:0]    control;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;

  // Decode/write-back/EX environment side.
  modport master (
    output in_valid, rs, rt, rd, alu_ctrl, use_imm, imm, reg_write,
    output wb_en, wb_addr, wb_data, ex_ready, flush,
    input  in_ready, ex_valid, read1, read2, control, ex_rd, ex_reg_write
  );

  // Operand stage side.
  modport slave (
    input  in_valid, rs, rt, rd, alu_ctrl, use_imm, imm, reg_write,
    input  wb_en, wb_addr, wb_data, ex_ready, flush,
    output in_ready, ex_valid, read1, read2, control, ex_rd, ex_reg_write
  );

endinterface

// File: rtl/operand_stage_regfile_2r1w.sv
// Register file: two combinational read ports with write-back bypass,
// one synchronous write port, r0 hardwired to zero.
module regfile_2r1w
  import operand_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [W-1:0]  o_rdata1,
  output logic [W-1:0]  o_rdata2
);

  logic [W-1:0] r_regs [NREG];

  // Write port; reset wins over a concurrent write, r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: zero for r0, then same-cycle write data, then stored value.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == '0)                     o_rdata1 = '0;
    else if (i_we && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == '0)                     o_rdata2 = '0;
    else if (i_we && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
  end

endmodule

// File: rtl/operand_stage.sv
// Operand stage: regfile read, busy scoreboard with RAW/WAW stall, and the
// ID/EX pipeline register feeding the ALU.
module operand_stage
  import operand_stage_pkg::*;
(
  input logic clk,
  input logic reset,
  operand_stage_if.slave bus
);

  logic [W-1:0]    w_rdata1;
  logic [W-1:0]    w_rdata2;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic [NREG-1:0] w_busy_eff;
  logic [NREG-1:0] w_wb_mask;
  logic            w_hazard;
  logic            w_adv;
  logic            w_in_ready;
  logic            w_accept;

  logic            r_ex_valid;
  logic [W-1:0]    r_read1;
  logic [W-1:0]    r_read2;
  logic [2:0]      r_control;
  logic [AW-1:0]   r_ex_rd;
  logic            r_ex_reg_write;

  regfile_2r1w u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_addr),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (bus.rs),
    .i_raddr2 (bus.rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Hazard check: a register being written back this cycle is already free,
  // because its value reaches the operand through the regfile bypass.
  always_comb begin
    w_wb_mask = '0;
    if (bus.wb_en) w_wb_mask[bus.wb_addr] = 1'b1;
    w_busy_eff = r_busy & ~w_wb_mask;
    w_hazard   = bus.in_valid &
                 (w_busy_eff[bus.rs] |
                  (~bus.use_imm & w_busy_eff[bus.rt]) |
                  (bus.reg_write & w_busy_eff[bus.rd]));
  end

  assign w_adv      = ~r_ex_valid | bus.ex_ready;
  assign w_in_ready = w_adv & ~w_hazard & ~reset;
  // A flushed incoming instruction still sees in_ready but is dropped here.
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;

  // Scoreboard update: write-back and flush clear, acceptance sets last so a
  // set and a clear of the same register in one cycle leaves it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (bus.wb_en) w_busy_next[bus.wb_addr] = 1'b0;
    if (bus.flush && r_ex_valid && r_ex_reg_write) w_busy_next[r_ex_rd] = 1'b0;
    if (w_accept && bus.reg_write && (bus.rd != '0)) w_busy_next[bus.rd] = 1'b1;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  // ID/EX pipeline register; bubbles only drop ex_valid, the payload holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_read1        <= '0;
      r_read2        <= '0;
      r_control      <= '0;
      r_ex_rd        <= '0;
      r_ex_reg_write <= 1'b0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_adv) begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_read1        <= w_rdata1;
        r_read2        <= bus.use_imm ? bus.imm : w_rdata2;
        r_control      <= bus.alu_ctrl;
        r_ex_rd        <= bus.rd;
        r_ex_reg_write <= bus.reg_write;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.read1        = r_read1;
  assign bus.read2        = r_read2;
  assign bus.control      = r_control;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.ex_reg_write = r_ex_reg_write;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios followed by
// randomized traffic, checked against a register/busy-list reference model.
module tb_operand_stage;
  import operand_stage_pkg::*;

  localparam int EW = 23;  // {read1, read2, control, ex_rd, ex_reg_write}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_stage_if bus ();

  operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [2:0]    pend_q[$];   // registers awaiting write-back downstream
  logic [7:0]    m_regs[8];
  bit            m_busy[8];
  bit            m_ex_valid;
  logic [2:0]    m_ex_rd;
  bit            m_ex_rw;
  bit            took;        // instruction left the issue side last cycle

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] src_val(logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit busy_op(logic [2:0] a);
    return m_busy[a] && !(bus.wb_en && bus.wb_addr == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    m_ex_valid = 1'b0;
    m_ex_rd    = 3'd0;
    m_ex_rw    = 1'b0;
    exp_q.delete();
    pend_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.rs        = 3'd0;
    bus.rt        = 3'd0;
    bus.rd        = 3'd0;
    bus.alu_ctrl  = 3'd0;
    bus.use_imm   = 1'b0;
    bus.imm       = 8'h00;
    bus.reg_write = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 3'd0;
    bus.wb_data   = 8'h00;
    bus.ex_ready  = 1'b1;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [2:0] ctl, input logic ui, input logic [7:0] imm,
                       input logic rw);
    bus.in_valid  = 1'b1;
    bus.rs        = rs;
    bus.rt        = rt;
    bus.rd        = rd;
    bus.alu_ctrl  = ctl;
    bus.use_imm   = ui;
    bus.imm       = imm;
    bus.reg_write = rw;
  endtask

  task automatic wb(input logic [2:0] a, input logic [7:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  // One clock: check handshake, advance the model to the next edge, return
  // just after the edge with inputs free to change.
  task automatic cycle();
    bit adv, haz, rdy, acc;
    @(negedge clk);
    adv = !m_ex_valid || bus.ex_ready;
    haz = bus.in_valid && (busy_op(bus.rs) || (!bus.use_imm && busy_op(bus.rt)) ||
                           (bus.reg_write && busy_op(bus.rd)));
    rdy = adv && !haz && !reset;
    check("in_ready", bus.in_ready, rdy);
    check("ex_valid", bus.ex_valid, m_ex_valid);
    took = bus.in_valid && rdy;
    if (reset) begin
      model_reset();
    end else begin
      acc = took && !bus.flush;
      if (acc)
        exp_q.push_back({src_val(bus.rs), bus.use_imm ? bus.imm : src_val(bus.rt),
                         bus.alu_ctrl, bus.rd, bus.reg_write});
      if (m_ex_valid && bus.ex_ready && !bus.flush && m_ex_rw && m_ex_rd != 3'd0)
        pend_q.push_back(m_ex_rd);
      if (bus.wb_en) m_busy[bus.wb_addr] = 1'b0;
      if (bus.flush && m_ex_valid && m_ex_rw) m_busy[m_ex_rd] = 1'b0;
      if (acc && bus.reg_write && bus.rd != 3'd0) m_busy[bus.rd] = 1'b1;
      if (bus.wb_en && bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.flush) m_ex_valid = 1'b0;
      else if (adv) begin
        m_ex_valid = acc;
        if (acc) begin
          m_ex_rd = bus.rd;
          m_ex_rw = bus.reg_write;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.ex_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ex_output: valid output with no expected entry at %0t", $time);
        end else begin
          e = exp_q[0];
          check("read1", bus.read1, e[22:15]);
          check("read2", bus.read2, e[14:7]);
          check("control", bus.control, e[6:4]);
          check("ex_rd", bus.ex_rd, e[3:1]);
          check("ex_reg_write", bus.ex_reg_write, e[0]);
          if (bus.flush || bus.ex_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit held;
    model_reset();
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_read1", bus.read1, 8'h00);
    check("rst_read2", bus.read2, 8'h00);
    check("rst_control", bus.control, 3'd0);
    check("rst_ex_rd", bus.ex_rd, 3'd0);
    check("rst_ex_reg_write", bus.ex_reg_write, 1'b0);
    check("rst_ex_valid", bus.ex_valid, 1'b0);

    // Write r3, then read it back through rs.
    wb(3'd3, 8'h5A);                         cycle();
    idle(); issue(3'd3, 3'd0, 3'd0, ALU_ADD, 1'b0, 8'h00, 1'b0); cycle();
    idle();                                  cycle();

    // RAW stall on r2 until its write-back, which bypasses into read1.
    issue(3'd0, 3'd0, 3'd2, ALU_SUB, 1'b0, 8'h00, 1'b1); cycle();
    idle(); issue(3'd2, 3'd0, 3'd1, ALU_AND, 1'b0, 8'h00, 1'b0); cycle();
    cycle();
    wb(3'd2, 8'h11);                         cycle();
    idle();                                  cycle();

    // Immediate operand ignores a busy rt.
    issue(3'd0, 3'd0, 3'd5, ALU_OR, 1'b0, 8'h00, 1'b1); cycle();
    idle(); issue(3'd3, 3'd5, 3'd1, ALU_XOR, 1'b1, 8'hF0, 1'b0); cycle();
    idle(); wb(3'd5, 8'h33);                 cycle();
    idle();                                  cycle();

    // Backpressure: output held three cycles, then the next instruction loads.
    issue(3'd3, 3'd2, 3'd0, ALU_SLT, 1'b0, 8'h00, 1'b0); cycle();
    issue(3'd5, 3'd3, 3'd0, ALU_NOT, 1'b0, 8'h00, 1'b0);
    bus.ex_ready = 1'b0;
    cycle(); cycle(); cycle();
    bus.ex_ready = 1'b1;                     cycle();
    idle();                                  cycle();

    // Flush of a writing instruction frees its destination.
    issue(3'd0, 3'd0, 3'd4, ALU_ADD, 1'b0, 8'h00, 1'b1);
    bus.ex_ready = 1'b0;                     cycle();
    idle(); bus.ex_ready = 1'b0; bus.flush = 1'b1; cycle();
    idle(); issue(3'd4, 3'd0, 3'd0, ALU_ADD, 1'b0, 8'h00, 1'b0); cycle();
    idle();                                  cycle();

    // Writes to r0 are dropped.
    wb(3'd0, 8'hFF);                         cycle();
    idle(); issue(3'd0, 3'd0, 3'd0, ALU_ADD, 1'b0, 8'h00, 1'b0); cycle();
    idle();                                  cycle();

    // Reset while EX holds an instruction; the concurrent write-back is lost.
    issue(3'd2, 3'd3, 3'd6, ALU_ADD, 1'b0, 8'h00, 1'b1);
    bus.ex_ready = 1'b0;                     cycle();
    idle(); bus.ex_ready = 1'b0; reset = 1'b1; wb(3'd1, 8'h77); cycle();
    reset = 1'b0;
    idle(); issue(3'd1, 3'd3, 3'd0, ALU_ADD, 1'b0, 8'h00, 1'b0); cycle();
    idle();                                  cycle();

    // Randomized traffic with a model-driven write-back stage.
    held = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.rs        = 3'($urandom_range(0, 7));
        bus.rt        = 3'($urandom_range(0, 7));
        bus.rd        = 3'($urandom_range(0, 7));
        bus.alu_ctrl  = 3'($urandom_range(0, 6));
        bus.use_imm   = ($urandom_range(0, 3) == 0);
        bus.imm       = 8'($urandom);
        bus.reg_write = ($urandom_range(0, 1) == 1);
      end
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 31) == 0);
      bus.wb_en    = 1'b0;
      bus.wb_addr  = 3'd0;
      bus.wb_data  = 8'($urandom);
      if (pend_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        bus.wb_en   = 1'b1;
        bus.wb_addr = pend_q.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.wb_en   = 1'b1;
        bus.wb_addr = 3'($urandom_range(0, 7));
      end
      reset = (n == 1500);
      cycle();
      held = bus.in_valid && !took;
    end
    reset = 1'b0;

    // Drain.
    idle();
    for (int n = 0; n < 4; n++) cycle();
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
